// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Input stage in front of the 4-bit ALU. The module synchronizes the board switches.
//   It synchronizes and debounces the two push buttons, turning each clean press into a
//   one-cycle pulse. A small FSM uses those pulses to capture operand A, operand B, and then
//   {op, mode, c_in}. The captured values drive the ALU directly from registers.
//   Ports:
//     clk, rst             single clock domain; rst is synchronous and active-high
//     sw_data/op/mode/cin  raw switch levels (asynchronous)
//     btn_next, btn_clear  raw, bouncy push buttons (asynchronous)
//     a, b, op, mode, c_in registered operand set
//     operands_valid       one-cycle strobe after the opcode capture completes a set
//     state                FSM state for the LEDs (00 A, 01 B, 10 OP, 11 RUN)
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DATA_W          = 4,
    parameter int unsigned OP_W            = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [OP_W-1:0]   sw_op,
    input  logic              sw_mode,
    input  logic              sw_cin,
    input  logic              btn_next,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op,
    output logic              mode,
    output logic              c_in,
    output logic              operands_valid,
    output logic [1:0]        state
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SW_W  = DATA_W + OP_W + 2;
    localparam int unsigned BTN_NEXT  = 0;
    localparam int unsigned BTN_CLEAR = 1;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    logic [SW_W-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [1:0]        btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [1:0]        lvl_q, lvl_d;
    logic [1:0]        press_q, press_d;
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              mode_q, mode_d, c_in_q, c_in_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] sw_data_s;
    logic [OP_W-1:0]   sw_op_s;
    logic              sw_mode_s, sw_cin_s;

    assign sw_data_s = sw_s2_q[SW_W-1 -: DATA_W];
    assign sw_op_s   = sw_s2_q[OP_W+1 -: OP_W];
    assign sw_mode_s = sw_s2_q[1];
    assign sw_cin_s  = sw_s2_q[0];

    // Input conditioning. A debounce counter runs only while the synced value differs
    // from the accepted level; agreement zeroes it. A press pulse is produced on a 0->1
    // acceptance and registered, so the FSM sees it one cycle after the level change.
    always_comb begin
        sw_s1_d  = {sw_data, sw_op, sw_mode, sw_cin};
        sw_s2_d  = sw_s1_q;
        btn_s1_d = {btn_clear, btn_next};
        btn_s2_d = btn_s1_q;
        lvl_d    = lvl_q;
        press_d  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (btn_s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[i]   = btn_s2_q[i];
                    press_d[i] = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Operand FSM: clear outranks next.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        mode_d  = mode_q;
        c_in_d  = c_in_q;
        valid_d = 1'b0;
        if (press_q[BTN_CLEAR]) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            mode_d  = 1'b0;
            c_in_d  = 1'b0;
        end else if (press_q[BTN_NEXT]) begin
            unique case (state_q)
                S_A: begin
                    a_d     = sw_data_s;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_data_s;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = sw_op_s;
                    mode_d  = sw_mode_s;
                    c_in_d  = sw_cin_s;
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            lvl_q    <= '0;
            press_q  <= '0;
            cnt_q    <= '{default: '0};
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mode_q   <= 1'b0;
            c_in_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            lvl_q    <= lvl_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            c_in_q   <= c_in_d;
            valid_q  <= valid_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign op             = op_q;
    assign mode           = mode_q;
    assign c_in           = c_in_q;
    assign operands_valid = valid_q;
    assign state          = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw_data = '0;
    logic [2:0] sw_op = '0;
    logic       sw_mode = 1'b0;
    logic       sw_cin = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] a, b;
    logic [2:0] op;
    logic       mode, c_in, operands_valid;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int v0;

    alu_operand_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .DATA_W(4),
        .OP_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .sw_data(sw_data), .sw_op(sw_op), .sw_mode(sw_mode), .sw_cin(sw_cin),
        .btn_next(btn_next), .btn_clear(btn_clear),
        .a(a), .b(b), .op(op), .mode(mode), .c_in(c_in),
        .operands_valid(operands_valid), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (operands_valid === 1'b1) valid_cnt++;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: hold long enough to be accepted, then release long enough to settle.
    task automatic press(input logic nxt, input logic clr);
        btn_next  = nxt;
        btn_clear = clr;
        cycles(12);
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        cycles(12);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cycles(3);
        @(negedge clk);
        total++; if (a !== 4'h0) begin bad++; $display("FAIL reset_a got=%0h want=0", a); end
        total++; if (b !== 4'h0) begin bad++; $display("FAIL reset_b got=%0h want=0", b); end
        total++; if (op !== 3'b000) begin bad++; $display("FAIL reset_op got=%0b want=000", op); end
        total++; if ({mode, c_in} !== 2'b00) begin bad++; $display("FAIL reset_mode_cin got=%0b want=00", {mode, c_in}); end
        total++; if (operands_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", operands_valid); end
        total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0b want=00", state); end
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_sequence;
        sw_data = 4'h5;
        press(1'b1, 1'b0);
        total++; if (a !== 4'h5) begin bad++; $display("FAIL seq_a got=%0h want=5", a); end
        total++; if (state !== 2'b01) begin bad++; $display("FAIL seq_state_b got=%0b want=01", state); end
        // Switch motion without a press must not disturb anything.
        sw_data = 4'hF;
        cycles(20);
        total++; if (a !== 4'h5) begin bad++; $display("FAIL noprs_a got=%0h want=5", a); end
        total++; if (state !== 2'b01) begin bad++; $display("FAIL noprs_state got=%0b want=01", state); end
        sw_data = 4'h3;
        press(1'b1, 1'b0);
        total++; if (b !== 4'h3) begin bad++; $display("FAIL seq_b got=%0h want=3", b); end
        total++; if (state !== 2'b10) begin bad++; $display("FAIL seq_state_op got=%0b want=10", state); end
        sw_op = 3'b010; sw_mode = 1'b1; sw_cin = 1'b0;
        v0 = valid_cnt;
        press(1'b1, 1'b0);
        total++; if (op !== 3'b010) begin bad++; $display("FAIL seq_op got=%0b want=010", op); end
        total++; if ({mode, c_in} !== 2'b10) begin bad++; $display("FAIL seq_mode_cin got=%0b want=10", {mode, c_in}); end
        total++; if (state !== 2'b11) begin bad++; $display("FAIL seq_state_run got=%0b want=11", state); end
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL seq_valid_cycles got=%0d want=1", valid_cnt - v0); end
        total++; if ({a, b} !== 8'h53) begin bad++; $display("FAIL seq_ab_kept got=%0h want=53", {a, b}); end
    endtask

    task automatic test_run_next;
        v0 = valid_cnt;
        press(1'b1, 1'b0);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL run_state got=%0b want=00", state); end
        total++; if ({a, b} !== 8'h53) begin bad++; $display("FAIL run_ab got=%0h want=53", {a, b}); end
        total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL run_valid got=%0d want=0", valid_cnt - v0); end
        sw_data = 4'h9;
        press(1'b1, 1'b0);
        total++; if (a !== 4'h9) begin bad++; $display("FAIL run_a9 got=%0h want=9", a); end
        total++; if (b !== 4'h3) begin bad++; $display("FAIL run_b3 got=%0h want=3", b); end
        total++; if (state !== 2'b01) begin bad++; $display("FAIL run_state_b got=%0b want=01", state); end
    endtask

    task automatic test_clear_and_next;
        v0 = valid_cnt;
        press(1'b1, 1'b1);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL clr_state got=%0b want=00", state); end
        total++; if ({a, b} !== 8'h00) begin bad++; $display("FAIL clr_ab got=%0h want=00", {a, b}); end
        total++; if ({op, mode, c_in} !== 5'b0) begin bad++; $display("FAIL clr_op_mode_cin got=%0b want=00000", {op, mode, c_in}); end
        total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL clr_valid got=%0d want=0", valid_cnt - v0); end
    endtask

    task automatic test_bounce;
        sw_data = 4'h7;
        for (int i = 0; i < 6; i++) begin
            btn_next = ~btn_next;
            cycles(2);
        end
        total++; if (state !== 2'b00) begin bad++; $display("FAIL bounce_none got=%0b want=00", state); end
        btn_next = 1'b1;
        cycles(10);
        btn_next = 1'b0;
        cycles(12);
        total++; if (state !== 2'b01) begin bad++; $display("FAIL bounce_state got=%0b want=01", state); end
        total++; if (a !== 4'h7) begin bad++; $display("FAIL bounce_a got=%0h want=7", a); end
    endtask

    task automatic test_reset_mid;
        sw_data = 4'h4;
        press(1'b1, 1'b0);
        total++; if (state !== 2'b10) begin bad++; $display("FAIL mid_pre_state got=%0b want=10", state); end
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL mid_state got=%0b want=00", state); end
        total++; if ({a, b} !== 8'h00) begin bad++; $display("FAIL mid_ab got=%0h want=00", {a, b}); end
    endtask

    task automatic test_held_through_reset;
        sw_data  = 4'h6;
        btn_next = 1'b1;
        rst      = 1'b1;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL held_early got=%0b want=00", state); end
        cycles(15);
        btn_next = 1'b0;
        cycles(12);
        total++; if (state !== 2'b01) begin bad++; $display("FAIL held_state got=%0b want=01", state); end
        total++; if (a !== 4'h6) begin bad++; $display("FAIL held_a got=%0h want=6", a); end
    endtask

    initial begin
        cycles(1);
        test_reset();
        test_sequence();
        test_run_next();
        test_clear_and_next();
        test_bounce();
        test_reset_mid();
        test_held_through_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
